// File: rtl/reorder_buffer_mp.sv
// reorder_buffer_mp: ROB with dispatch (in_*, alloc_idx), CPL_PORTS completions (cpl_*), SRC_PORTS tag lookups with bypass (src_*), RETIRE_W in-order retire (retire_*), tail-rollback flush (flush_*) and count-based occupancy (rob_*)
module reorder_buffer_mp #(
  parameter int ROB_DEPTH = 64,
  parameter int RETIRE_W = 2,
  parameter int CPL_PORTS = 3,
  parameter int SRC_PORTS = 2,
  parameter int PC_W = 8,
  parameter int AREG_W = 5,
  parameter int TAG_W = 6,
  parameter int DATA_W = 32,
  parameter int IDX_W = $clog2(ROB_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [AREG_W-1:0] in_arch_rd,
  input  logic [TAG_W-1:0]  in_tag_rd,
  output logic              in_ready,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              cpl_valid [CPL_PORTS],
  input  logic [IDX_W-1:0]  cpl_idx [CPL_PORTS],
  input  logic [DATA_W-1:0] cpl_data [CPL_PORTS],
  input  logic [TAG_W-1:0]  src_tag [SRC_PORTS],
  output logic              src_hit [SRC_PORTS],
  output logic [DATA_W-1:0] src_data [SRC_PORTS],
  input  logic              retire_stall,
  output logic              retire_valid [RETIRE_W],
  output logic [PC_W-1:0]   retire_pc [RETIRE_W],
  output logic [AREG_W-1:0] retire_reg [RETIRE_W],
  output logic [TAG_W-1:0]  retire_tag [RETIRE_W],
  output logic [DATA_W-1:0] retire_data [RETIRE_W],
  input  logic              flush_valid,
  input  logic [IDX_W-1:0]  flush_idx,
  output logic [IDX_W:0]    rob_count,
  output logic              rob_full,
  output logic              rob_empty
);
  logic [ROB_DEPTH-1:0] vld, done, squash;
  logic [PC_W-1:0] pc_q [ROB_DEPTH];
  logic [AREG_W-1:0] rd_q [ROB_DEPTH];
  logic [TAG_W-1:0] tag_q [ROB_DEPTH];
  logic [DATA_W-1:0] data_q [ROB_DEPTH];
  logic [IDX_W-1:0] head, tail, keep_off;
  logic [IDX_W-1:0] ridx [RETIRE_W];
  logic [IDX_W:0] count, nret;
  logic push, chain;
  assign rob_count = count;
  assign rob_full = count == (IDX_W+1)'(ROB_DEPTH);
  assign rob_empty = count == '0;
  assign in_ready = ~rob_full & ~stall_in & ~flush_valid;
  assign alloc_idx = tail;
  assign push = in_valid & in_ready;
  assign keep_off = flush_idx - head;
  always_comb begin
    nret = '0;
    chain = ~retire_stall & ~flush_valid;
    for (int k = 0; k < RETIRE_W; k++) begin
      ridx[k] = head + IDX_W'(k);
      chain = chain & vld[ridx[k]] & done[ridx[k]];
      retire_valid[k] = chain;
      retire_pc[k] = pc_q[ridx[k]];
      retire_reg[k] = rd_q[ridx[k]];
      retire_tag[k] = tag_q[ridx[k]];
      retire_data[k] = data_q[ridx[k]];
      nret = nret + (IDX_W+1)'(chain);
    end
  end
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++)
      squash[i] = (IDX_W'(i) - flush_idx - IDX_W'(1)) < (tail - flush_idx - IDX_W'(1));
  end
  always_comb begin
    for (int s = 0; s < SRC_PORTS; s++) begin
      src_hit[s] = 1'b0;
      src_data[s] = '0;
      for (int i = 0; i < ROB_DEPTH; i++)
        if (vld[i] && done[i] && tag_q[i] == src_tag[s]) begin
          src_hit[s] = 1'b1;
          src_data[s] = data_q[i];
        end
      for (int p = 0; p < CPL_PORTS; p++)
        if (cpl_valid[p] && vld[cpl_idx[p]] && tag_q[cpl_idx[p]] == src_tag[s]) begin
          src_hit[s] = 1'b1;
          src_data[s] = cpl_data[p];
        end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      vld <= '0;
      done <= '0;
    end else begin
      for (int p = 0; p < CPL_PORTS; p++)
        if (cpl_valid[p] && vld[cpl_idx[p]] && !(flush_valid && squash[cpl_idx[p]])) begin
          done[cpl_idx[p]] <= 1'b1;
          data_q[cpl_idx[p]] <= cpl_data[p];
        end
      if (flush_valid) begin
        for (int i = 0; i < ROB_DEPTH; i++)
          if (squash[i]) begin
            vld[i] <= 1'b0;
            done[i] <= 1'b0;
          end
        tail <= flush_idx + IDX_W'(1);
        count <= {1'b0, keep_off} + (IDX_W+1)'(1);
      end else begin
        for (int k = 0; k < RETIRE_W; k++)
          if (retire_valid[k]) begin
            vld[ridx[k]] <= 1'b0;
            done[ridx[k]] <= 1'b0;
          end
        if (push) begin
          vld[tail] <= 1'b1;
          done[tail] <= 1'b0;
          pc_q[tail] <= in_pc;
          rd_q[tail] <= in_arch_rd;
          tag_q[tail] <= in_tag_rd;
          data_q[tail] <= '0;
          tail <= tail + IDX_W'(1);
        end
        head <= head + nret[IDX_W-1:0];
        count <= count + (IDX_W+1)'(push) - nret;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer_mp.sv
// tb_reorder_buffer_mp: directed and randomized scoreboard bench for reorder_buffer_mp against a queue-based ROB model
module tb_reorder_buffer_mp;
  localparam int D = 64, RW = 2, CP = 3, SP = 2;
  logic clk = 1'b0, rst, stall_in, in_valid, in_ready, retire_stall, flush_valid, rob_full, rob_empty;
  logic [7:0] in_pc;
  logic [4:0] in_arch_rd;
  logic [5:0] in_tag_rd, alloc_idx, flush_idx;
  logic cpl_valid [CP];
  logic [5:0] cpl_idx [CP];
  logic [31:0] cpl_data [CP];
  logic [5:0] src_tag [SP];
  logic src_hit [SP];
  logic [31:0] src_data [SP];
  logic retire_valid [RW];
  logic [7:0] retire_pc [RW];
  logic [4:0] retire_reg [RW];
  logic [5:0] retire_tag [RW];
  logic [31:0] retire_data [RW];
  logic [6:0] rob_count;
  typedef struct packed {logic [5:0] idx; logic [7:0] pc; logic [4:0] rd; logic [5:0] tag; logic [31:0] data; logic done;} ent_t;
  typedef struct packed {logic [7:0] pc; logic [4:0] rd; logic [5:0] tag; logic [31:0] data;} ret_t;
  typedef struct packed {logic [6:0] count; logic full; logic empty; logic rdy; logic [5:0] alloc; logic [2:0] nret; logic [SP-1:0] hit; logic [SP-1:0][31:0] sdata;} st_t;
  ent_t m_rob[$];
  ret_t ret_q[$];
  st_t st_q[$];
  int mhead = 0, errors = 0, checks = 0;
  reorder_buffer_mp dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .in_valid(in_valid), .in_pc(in_pc),
    .in_arch_rd(in_arch_rd), .in_tag_rd(in_tag_rd), .in_ready(in_ready), .alloc_idx(alloc_idx),
    .cpl_valid(cpl_valid), .cpl_idx(cpl_idx), .cpl_data(cpl_data), .src_tag(src_tag),
    .src_hit(src_hit), .src_data(src_data), .retire_stall(retire_stall), .retire_valid(retire_valid),
    .retire_pc(retire_pc), .retire_reg(retire_reg), .retire_tag(retire_tag), .retire_data(retire_data),
    .flush_valid(flush_valid), .flush_idx(flush_idx), .rob_count(rob_count), .rob_full(rob_full),
    .rob_empty(rob_empty)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int mtail();
    return (mhead + m_rob.size()) % D;
  endfunction
  function automatic int mpos(logic [5:0] idx);
    return (int'(idx) - mhead + D) % D;
  endfunction
  task automatic idle();
    rst = 0; stall_in = 0; in_valid = 0; in_pc = 0; in_arch_rd = 0; in_tag_rd = 0;
    retire_stall = 0; flush_valid = 0; flush_idx = 0;
    for (int p = 0; p < CP; p++) begin
      cpl_valid[p] = 0; cpl_idx[p] = 0; cpl_data[p] = 0;
    end
    for (int s = 0; s < SP; s++) src_tag[s] = 0;
  endtask
  task automatic set_disp();
    in_valid = 1; in_pc = 8'(mtail()); in_arch_rd = 5'($urandom); in_tag_rd = 6'(mtail() ^ 12);
  endtask
  task automatic cpl(int p, int idx, logic [31:0] d);
    cpl_valid[p] = 1; cpl_idx[p] = 6'(idx); cpl_data[p] = d;
  endtask
  task automatic step();
    st_t s;
    ret_t r;
    ent_t e;
    int n, keep, pos, nret;
    n = m_rob.size();
    for (int p = 0; p < CP; p++)
      for (int q = p + 1; q < CP; q++)
        assert (!(cpl_valid[p] && cpl_valid[q] && cpl_idx[p] == cpl_idx[q])) else $error("two completion ports share an index");
    if (flush_valid) assert (mpos(flush_idx) < n) else $error("flush_idx names no live entry");
    s.count = 7'(n); s.full = n == D; s.empty = n == 0;
    s.rdy = n != D && !stall_in && !flush_valid;
    s.alloc = 6'(mtail());
    nret = 0;
    if (!retire_stall && !flush_valid)
      while (nret < RW && nret < n && m_rob[nret].done) begin
        r.pc = m_rob[nret].pc; r.rd = m_rob[nret].rd; r.tag = m_rob[nret].tag; r.data = m_rob[nret].data;
        ret_q.push_back(r);
        nret++;
      end
    s.nret = 3'(nret);
    for (int sp = 0; sp < SP; sp++) begin
      s.hit[sp] = 0; s.sdata[sp] = 0;
      for (int i = 0; i < n; i++)
        if (m_rob[i].done && m_rob[i].tag == src_tag[sp]) begin
          s.hit[sp] = 1; s.sdata[sp] = m_rob[i].data;
        end
      for (int p = 0; p < CP; p++)
        if (cpl_valid[p] && mpos(cpl_idx[p]) < n && m_rob[mpos(cpl_idx[p])].tag == src_tag[sp]) begin
          s.hit[sp] = 1; s.sdata[sp] = cpl_data[p];
        end
    end
    st_q.push_back(s);
    if (rst) begin
      m_rob.delete();
      mhead = 0;
    end else begin
      keep = flush_valid ? mpos(flush_idx) + 1 : n;
      for (int p = 0; p < CP; p++) begin
        pos = mpos(cpl_idx[p]);
        if (cpl_valid[p] && pos < keep) begin
          e = m_rob[pos]; e.done = 1; e.data = cpl_data[p]; m_rob[pos] = e;
        end
      end
      if (flush_valid) begin
        while (m_rob.size() > keep) void'(m_rob.pop_back());
      end else begin
        for (int i = 0; i < nret; i++) void'(m_rob.pop_front());
        mhead = (mhead + nret) % D;
        if (in_valid && s.rdy) begin
          e.idx = s.alloc; e.pc = in_pc; e.rd = in_arch_rd; e.tag = in_tag_rd; e.data = 0; e.done = 0;
          m_rob.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask
  task automatic disp(int cnt);
    repeat (cnt) begin
      idle(); set_disp(); step();
    end
  endtask
  task automatic do_reset();
    idle(); rst = 1; step(); idle();
  endtask
  initial begin
    st_t s;
    ret_t r;
    forever begin
      @(negedge clk);
      #2;
      if (st_q.size() != 0) begin
        s = st_q.pop_front();
        chk("rob_count", rob_count, s.count);
        chk("rob_full", rob_full, s.full);
        chk("rob_empty", rob_empty, s.empty);
        chk("in_ready", in_ready, s.rdy);
        chk("alloc_idx", alloc_idx, s.alloc);
        for (int k = 0; k < RW; k++) begin
          chk("retire_valid", retire_valid[k], k < s.nret);
          if (k < s.nret && ret_q.size() != 0) begin
            r = ret_q.pop_front();
            chk("retire_pc", retire_pc[k], r.pc);
            chk("retire_reg", retire_reg[k], r.rd);
            chk("retire_tag", retire_tag[k], r.tag);
            chk("retire_data", retire_data[k], r.data);
          end
        end
        for (int sp = 0; sp < SP; sp++) begin
          chk("src_hit", src_hit[sp], s.hit[sp]);
          chk("src_data", src_data[sp], s.sdata[sp]);
        end
      end
    end
  end
  initial begin
    int n, idx, rate;
    bit dup;
    idle(); rst = 1;
    repeat (2) @(negedge clk);
    idle();
    // fill to capacity, 65th request refused
    do_reset(); disp(64);
    idle(); set_disp(); #1;
    chk("full_in_ready", in_ready, 0); chk("full_flag", rob_full, 1); chk("full_count", rob_count, 64);
    step();
    idle(); #1; chk("tail_after_65th", alloc_idx, 0); step();
    // out-of-order completion, in-order 2-wide retire
    do_reset(); disp(4);
    idle(); cpl(0, 1, 32'h11); cpl(1, 0, 32'h10); cpl(2, 3, 32'h13); step();
    idle(); #1;
    chk("rv_first0", retire_valid[0], 1); chk("rv_first1", retire_valid[1], 1); chk("rpc_first0", retire_pc[0], 0);
    step();
    idle(); #1; chk("rv_blocked0", retire_valid[0], 0); chk("rv_blocked1", retire_valid[1], 0); step();
    idle(); cpl(0, 2, 32'h12); step();
    idle(); #1;
    chk("rv_second0", retire_valid[0], 1); chk("rpc_idx2", retire_pc[0], 2); chk("rpc_idx3", retire_pc[1], 3);
    chk("rdata_idx3", retire_data[1], 32'h13);
    step();
    // same-cycle bypass, then stored result
    do_reset(); disp(6);
    idle(); cpl(2, 5, 32'hDEADBEEF); src_tag[0] = 9; #1;
    chk("bypass_hit", src_hit[0], 1); chk("bypass_data", src_data[0], 32'hDEADBEEF);
    step();
    idle(); src_tag[0] = 9; #1;
    chk("stored_hit", src_hit[0], 1); chk("stored_data", src_data[0], 32'hDEADBEEF);
    step();
    // flush rollback with a completion to a squashed entry
    do_reset(); disp(10);
    idle(); flush_valid = 1; flush_idx = 4; cpl(0, 7, 32'h77); #1; chk("flush_in_ready", in_ready, 0); step();
    idle(); src_tag[0] = 6'(7 ^ 12); #1;
    chk("flush_count", rob_count, 5); chk("flush_tail", alloc_idx, 5); chk("squashed_cpl", src_hit[0], 0);
    step();
    // wrap: head 62, tail 2
    do_reset(); disp(62);
    for (int i = 0; i < 62; i += 3) begin
      idle();
      for (int p = 0; p < CP; p++) if (i + p < 62) cpl(p, i + p, 32'(i + p + 100));
      step();
    end
    for (int g = 0; g < 100 && m_rob.size() > 0; g++) begin
      idle(); step();
    end
    disp(4);
    idle(); cpl(0, 62, 32'h62); cpl(1, 63, 32'h63); cpl(2, 0, 32'h40); step();
    idle(); set_disp(); #1;
    chk("wrap_rpc0", retire_pc[0], 62); chk("wrap_rpc1", retire_pc[1], 63); chk("wrap_count_pre", rob_count, 4);
    step();
    idle(); #1;
    chk("wrap_count_post", rob_count, 3); chk("wrap_rpc_next", retire_pc[0], 0); chk("wrap_rv1", retire_valid[1], 0);
    step();
    // reset mid-stream with a pending flush
    do_reset(); disp(30);
    idle(); for (int p = 0; p < CP; p++) cpl(p, p, 32'(p + 1)); step();
    idle(); rst = 1; flush_valid = 1; flush_idx = 10; cpl(0, 20, 32'h1); step();
    idle(); #1;
    chk("rst_empty", rob_empty, 1); chk("rst_tail", alloc_idx, 0); chk("rst_count", rob_count, 0);
    chk("rst_rv0", retire_valid[0], 0); chk("rst_rv1", retire_valid[1], 0);
    step();
    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      idle();
      n = m_rob.size();
      rate = ((c / 500) % 4) * 2;
      if ($urandom_range(299) == 0) rst = 1;
      stall_in = $urandom_range(7) == 0;
      retire_stall = $urandom_range(7) == 0;
      if ($urandom_range(99) < 70) set_disp();
      if (n > 0 && $urandom_range(24) == 0) begin
        flush_valid = 1; flush_idx = 6'((mhead + int'($urandom_range(n - 1))) % D);
      end
      for (int p = 0; p < CP; p++)
        if (int'($urandom_range(7)) < rate) begin
          idx = (mhead + int'($urandom_range(n + 1))) % D;
          dup = 0;
          for (int q = 0; q < p; q++) if (cpl_valid[q] && int'(cpl_idx[q]) == idx) dup = 1;
          if (!dup) cpl(p, idx, $urandom);
        end
      for (int s = 0; s < SP; s++) src_tag[s] = 6'($urandom);
      step();
    end
    idle();
    #3;
    chk("retire_queue_drained", 64'(ret_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
